// File: rtl/counter_64_bit_reader_pkg.sv
// Shared widths and reader state type for the 64-bit counter and its read-side companion.
package counter_64_bit_pkg;

   localparam int unsigned WIDTH_DEFAULT = 64;
   localparam int unsigned CHUNK_DEFAULT = 16;

   typedef enum logic {
      IDLE,
      SEND
   } rd_state_t;

endpackage

// File: rtl/counter_64_bit_reader_if.sv
// Narrow valid/ready beat channel carrying snapshot chunks out of the reader.
interface counter_64_bit_reader_if
   import counter_64_bit_pkg::*;
#(
   parameter int unsigned CHUNK = CHUNK_DEFAULT
);

   logic [CHUNK-1:0] dout;
   logic             dvalid;
   logic             dready;
   logic             dlast;

   modport master (
      output dout,
      output dvalid,
      output dlast,
      input  dready
   );

   modport slave (
      input  dout,
      input  dvalid,
      input  dlast,
      output dready
   );

endinterface

// File: rtl/counter_64_bit_reader.sv
// Atomic snapshot of the live counter value, streamed out LSB chunk first as
// CHUNK-wide beats. Requests arriving mid-stream are dropped and flagged,
// except on the final-beat handshake where a new snapshot starts back-to-back.
module counter_64_bit_reader
   import counter_64_bit_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         cnt,
   input  logic                     req,
   output logic                     busy,
   output logic                     drop,
   counter_64_bit_reader_if.master  dbus
);

   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % CHUNK) != 0 || N < 2) begin : g_bad_params
      $error("counter_64_bit_reader: WIDTH must be a multiple of CHUNK with at least two beats");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   rd_state_t                   state, state_n;
   logic [N-1:0][CHUNK-1:0]     snap, snap_n;
   logic [IDX_W-1:0]            idx, idx_n;
   logic                        drop_n;
   logic                        hs;
   logic                        at_last;

   // State register, snapshot and beat index; asynchronous reset abandons any transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         snap  <= '0;
         idx   <= '0;
         drop  <= 1'b0;
      end else begin
         state <= state_n;
         snap  <= snap_n;
         idx   <= idx_n;
         drop  <= drop_n;
      end
   end

   // Next-state: capture on request when idle or when the last beat is handing off.
   always_comb begin
      state_n = state;
      snap_n  = snap;
      idx_n   = idx;
      drop_n  = 1'b0;
      at_last = (idx == LAST_IDX);
      hs      = (state == SEND) && dbus.dready;

      case (state)
         IDLE: begin
            if (req) begin
               snap_n  = cnt;
               idx_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (hs && at_last) begin
               if (req) begin
                  snap_n = cnt;
                  idx_n  = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               if (hs) begin
                  idx_n = idx + 1'b1;
               end
               drop_n = req;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Beat outputs decode only registered state, so no input reaches an output combinationally.
   always_comb begin
      busy        = (state == SEND);
      dbus.dvalid = busy;
      dbus.dlast  = busy && (idx == LAST_IDX);
      dbus.dout   = busy ? snap[idx] : '0;
   end

endmodule
